// File: rtl/addr_sub32b_seq.sv
// Sequential 32-bit address subtractor: d = a - b mod 2^32, CHUNK bits per cycle, LSB first.
// Define ADDR_SUB_UNDERFLOW_EN to expose the final borrow (a < b unsigned) on port 'borrow'.

module addr_sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);
  logic [W:0] r;

  // One extra bit catches the borrow: the true result lies in [-2^W, 2^W).
  assign r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
  assign diff = r[W-1:0];
  assign bout = r[W];
endmodule

module addr_sub32b_seq #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d
`ifdef ADDR_SUB_UNDERFLOW_EN
  ,
  output logic        borrow
`endif
);
  localparam int NCYC = 32 / CHUNK;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [31:0]      d_q;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic [CHUNK-1:0] a_k, b_k, d_k;
  logic             brw_nxt;

  always_comb begin
    a_k = op_q.a[int'(cnt) * CHUNK +: CHUNK];
    b_k = op_q.b[int'(cnt) * CHUNK +: CHUNK];
  end

  addr_sub_chunk #(.W(CHUNK)) u_chunk (
    .x    (a_k),
    .y    (b_k),
    .bin  (brw),
    .diff (d_k),
    .bout (brw_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = BUSY;
      BUSY:    if (cnt == LAST)   state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      d_q   <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          op_q <= '{a: a, b: b};
          cnt  <= '0;
          brw  <= 1'b0;
        end
        BUSY: begin
          // Borrow crosses chunk boundaries only through the brw flop.
          d_q[int'(cnt) * CHUNK +: CHUNK] <= d_k;
          brw <= brw_nxt;
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign d         = d_q;
`ifdef ADDR_SUB_UNDERFLOW_EN
  assign borrow    = brw;
`endif
endmodule

// File: tb/tb_addr_sub32b_seq.sv
// Scoreboard bench for addr_sub32b_seq: CHUNK=8 main instance plus CHUNK=1 and CHUNK=32 builds.

module tb_addr_sub32b_seq;
  localparam int NCYC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, d;
  logic        iv1 = 1'b0, iv32 = 1'b0, ir1, ir32, ov1, ov32, x_ordy = 1'b1;
  logic [31:0] x_a = '0, x_b = '0, d1, d32;
`ifdef ADDR_SUB_UNDERFLOW_EN
  logic        borrow, br1, br32;
`endif

  int errors = 0, checks = 0, cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic        brw;
    int          acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addr_sub32b_seq #(.CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .d(d)
`ifdef ADDR_SUB_UNDERFLOW_EN
    , .borrow(borrow)
`endif
  );

  addr_sub32b_seq #(.CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(x_a), .b(x_b),
    .out_valid(ov1), .out_ready(x_ordy), .d(d1)
`ifdef ADDR_SUB_UNDERFLOW_EN
    , .borrow(br1)
`endif
  );

  addr_sub32b_seq #(.CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(x_a), .b(x_b),
    .out_valid(ov32), .out_ready(x_ordy), .d(d32)
`ifdef ADDR_SUB_UNDERFLOW_EN
    , .borrow(br32)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: compare at negedge, retire at the handshake edge.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) prev_ov = 1'b0;
    else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 with d=0x%08h, required no result", d);
        end else if (!prev_ov) begin
          chk("d", d, sb[0].d);
`ifdef ADDR_SUB_UNDERFLOW_EN
          chk("borrow", {31'b0, borrow}, {31'b0, sb[0].brw});
`endif
          chk("latency", cyc - sb[0].acc, NCYC);
        end else begin
          chk("d_hold", d, sb[0].d);
`ifdef ADDR_SUB_UNDERFLOW_EN
          chk("borrow_hold", {31'b0, borrow}, {31'b0, sb[0].brw});
`endif
        end
        chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
      end
      prev_ov = out_valid;
    end
  end

  always @(posedge clk)
    if (rst_n && out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ed, input logic eb, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, required 1");
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    if (push) sb.push_back('{d: ed, brw: eb, acc: cyc});
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit seen1, seen32;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_d", d, 32'h0);
`ifdef ADDR_SUB_UNDERFLOW_EN
    chk("rst_borrow", {31'b0, borrow}, 32'd0);
`endif
    rst_n = 1'b1;

    issue(32'h0000_0010, 32'h0000_0004, 32'h0000_000C, 1'b0, 1'b1);
    issue(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b1);
    issue(32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(32'hDEAD_BEEF, 32'h0000_BEEF, 32'hDEAD_0000, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    issue(32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b1);
    drain();

    // Backpressure: hold for 10 cycles, then release.
    out_ready = 1'b0;
    issue(32'h00FF_0100, 32'h0000_0101, 32'h00FE_FFFF, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
    end
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    repeat (10) @(negedge clk);
    chk("bp_still_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    drain();

    // Abort mid-BUSY after two chunks; the partial result must vanish.
    issue(32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_d", d, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_result", {31'b0, out_valid}, 32'd0);
    issue(32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1);
    drain();

    // CHUNK=32 and CHUNK=1 builds side by side.
    @(negedge clk);
    x_a = 32'h8000_0000; x_b = 32'h7FFF_FFFF; iv1 = 1'b1; iv32 = 1'b1;
    chk("c1_in_ready", {31'b0, ir1}, 32'd1);
    chk("c32_in_ready", {31'b0, ir32}, 32'd1);
    @(negedge clk);
    iv1 = 1'b0; iv32 = 1'b0; x_a = $urandom; x_b = $urandom;
    c0 = cyc; seen1 = 1'b0; seen32 = 1'b0;
    for (int i = 0; i < 40 && !(seen1 && seen32); i++) begin
      if (ov32 && !seen32) begin
        seen32 = 1'b1;
        chk("c32_latency", cyc - c0, 32'd1);
        chk("c32_d", d32, 32'h0000_0001);
`ifdef ADDR_SUB_UNDERFLOW_EN
        chk("c32_borrow", {31'b0, br32}, 32'd0);
`endif
      end
      if (ov1 && !seen1) begin
        seen1 = 1'b1;
        chk("c1_latency", cyc - c0, 32'd32);
        chk("c1_d", d1, 32'h0000_0001);
`ifdef ADDR_SUB_UNDERFLOW_EN
        chk("c1_borrow", {31'b0, br1}, 32'd0);
`endif
      end
      if (!(seen1 && seen32)) @(negedge clk);
    end
    if (!seen1 || !seen32) begin
      checks++; errors++;
      $display("FAIL chunk_builds_timeout: got seen1=%0d seen32=%0d, required both 1", seen1, seen32);
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
